channel_slot_scheduler: RTL and testbench



---
 rtl/channel_slot_scheduler_pkg.sv | 47 ++++
 rtl/channel_slot_scheduler_if.sv | 26 ++
 rtl/channel_slot_scheduler_rr_arbiter.sv | 24 ++
 rtl/channel_slot_scheduler.sv | 141 ++++++++++++++
 tb/tb_channel_slot_scheduler.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_slot_scheduler_pkg.sv
// Shared types and helpers for the channel slot scheduler: FSM state encoding,
// one-hot expansion and the round-robin search used by the arbiter.
package sched_pkg;

  localparam int unsigned MaxCh = 16;
  localparam int unsigned IdxW  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StGrant,
    StGap
  } state_e;

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } rr_t;

  function automatic logic [MaxCh-1:0] onehot(input logic [IdxW-1:0] idx,
                                              input int unsigned nch);
    logic [MaxCh-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxCh; i++) begin
      if (i < nch && idx == i[IdxW-1:0]) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Search starts at last+1 and wraps at nch-1, so the previous winner is checked last.
  function automatic rr_t next_rr(input logic [MaxCh-1:0] req, input logic [IdxW-1:0] last,
                                  input int unsigned nch);
    rr_t         r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 1; k <= MaxCh; k++) begin
      c = 32'(last) + k;
      if (c >= nch) c = c - nch;
      if (k <= nch && !r.found && req[c[IdxW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[IdxW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/channel_slot_scheduler_if.sv
// Request/ack/grant bundle between the channel array and the slot scheduler.
interface channel_slot_scheduler_if #(
  parameter int unsigned NCH  = 9,
  parameter int unsigned ERRW = 8
);

  logic                     enable;
  logic [NCH-1:0]           req;
  logic [NCH-1:0]           ack;
  logic [NCH-1:0]           grant;
  logic [$clog2(NCH)-1:0]   grant_idx;
  logic                     special_active;
  logic                     timeout_err;
  logic [ERRW-1:0]          timeout_cnt;

  modport master (
    output enable, req, ack,
    input  grant, grant_idx, special_active, timeout_err, timeout_cnt
  );

  modport slave (
    input  enable, req, ack,
    output grant, grant_idx, special_active, timeout_err, timeout_cnt
  );

endinterface

// File: rtl/channel_slot_scheduler_rr_arbiter.sv
// Combinational round-robin search: first requesting channel after 'last', wrapping.
module rr_arbiter
  import sched_pkg::*;
#(
  parameter int unsigned NCH = 9
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] last,
  output logic [$clog2(NCH)-1:0] idx,
  output logic                   found
);

  logic [MaxCh-1:0] req_ext;
  rr_t              res;

  always_comb begin
    req_ext          = '0;
    req_ext[NCH-1:0] = req;
    res              = next_rr(req_ext, IdxW'(last), NCH);
    idx              = res.idx[$clog2(NCH)-1:0];
    found            = res.found;
  end

endmodule

// File: rtl/channel_slot_scheduler.sv
// Round-robin one-hot slot scheduler with per-channel minimum slot length, ack/timeout
// slot termination and a saturating timeout counter. All outputs are registered.
module channel_slot_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NCH              = 9,
  parameter int unsigned SPECIAL_IDX      = 8,
  parameter int unsigned SLOT_MIN         = 4,
  parameter int unsigned SPECIAL_SLOT_MIN = 8,
  parameter int unsigned TIMEOUT          = 16,
  parameter int unsigned ERRW             = 8
) (
  input logic                     clk40,
  input logic                     rstn,
  channel_slot_scheduler_if.slave bus
);

  localparam int unsigned IW = $clog2(NCH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]   MinNormal  = CW'(SLOT_MIN);
  localparam logic [CW-1:0]   MinSpecial = CW'(SPECIAL_SLOT_MIN);
  localparam logic [CW-1:0]   TmoCount   = CW'(TIMEOUT);
  localparam logic [ERRW-1:0] ErrMax     = '1;
  localparam logic [IW-1:0]   SpecIdx    = IW'(SPECIAL_IDX);
  localparam logic [IW-1:0]   LastRst    = IW'(NCH - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NCH-1:0]  grant_q, grant_d;
  logic            spec_q, spec_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ERRW-1:0] tcnt_q, tcnt_d;

  logic [IW-1:0]    arb_idx;
  logic             arb_found;
  logic [MaxCh-1:0] arb_oh;
  logic [CW-1:0]    slot_min;
  logic             ack_cur;
  logic             go;

  rr_arbiter #(
    .NCH(NCH)
  ) u_rr_arbiter (
    .req  (bus.req),
    .last (last_q),
    .idx  (arb_idx),
    .found(arb_found)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    spec_d   = spec_q;
    err_d    = 1'b0;
    done_d   = done_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    arb_oh   = onehot(IdxW'(arb_idx), NCH);
    slot_min = (idx_q == SpecIdx) ? MinSpecial : MinNormal;
    ack_cur  = bus.ack[idx_q];
    go       = bus.enable && (|bus.req);

    unique case (state_q)
      StIdle: begin
        if (go) state_d = StArb;
      end
      StArb: begin
        // req may have vanished since it was seen; fall back without granting.
        if (arb_found) begin
          grant_d = arb_oh[NCH-1:0];
          idx_d   = arb_idx;
          spec_d  = (arb_idx == SpecIdx);
          last_d  = arb_idx;
          cnt_d   = CW'(1);
          done_d  = 1'b0;
          state_d = StGrant;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        // An ack reaching min wins over a coincident timeout.
        if ((done_q || ack_cur) && cnt_q >= slot_min) begin
          grant_d = '0;
          spec_d  = 1'b0;
          state_d = StGap;
        end else if (cnt_q == TmoCount) begin
          grant_d = '0;
          spec_d  = 1'b0;
          err_d   = 1'b1;
          if (tcnt_q != ErrMax) tcnt_d = tcnt_q + 1'b1;
          state_d = StGap;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          done_d = done_q | ack_cur;
        end
      end
      StGap: begin
        state_d = go ? StArb : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk40 or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      last_q  <= LastRst;
      idx_q   <= '0;
      grant_q <= '0;
      spec_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      spec_q  <= spec_d;
      err_q   <= err_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.grant_idx      = idx_q;
  assign bus.special_active = spec_q;
  assign bus.timeout_err    = err_q;
  assign bus.timeout_cnt    = tcnt_q;

endmodule

// File: tb/tb_channel_slot_scheduler.sv
// Self-checking bench for channel_slot_scheduler: directed scenarios plus a randomized
// run, checked against a slot-level round-robin / slot-length model.
module tb_channel_slot_scheduler;

  localparam int NCH        = 9;
  localparam int SPECIAL    = 8;
  localparam int MIN_N      = 4;
  localparam int MIN_S      = 8;
  localparam int TIMEOUT    = 16;
  localparam int ERR_MAX    = 255;

  logic clk40;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  int   model_last;
  int   model_tmo;

  channel_slot_scheduler_if #(.NCH(NCH), .ERRW(8)) bus ();

  channel_slot_scheduler #(
    .NCH(NCH), .SPECIAL_IDX(SPECIAL), .SLOT_MIN(MIN_N), .SPECIAL_SLOT_MIN(MIN_S),
    .TIMEOUT(TIMEOUT), .ERRW(8)
  ) dut (
    .clk40(clk40),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk40 = 1'b0;
    forever #5 clk40 = ~clk40;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    bus.enable = 1'b0;
    bus.req    = '0;
    bus.ack    = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    model_last = NCH - 1;
    model_tmo  = 0;
  endtask

  // Reference: first requester after 'last' in circular order.
  function automatic int rr_next(input logic [NCH-1:0] r, input int last);
    for (int k = 1; k <= NCH; k++) begin
      int c = (last + k) % NCH;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic int slot_len(input int idx, input logic [NCH-1:0] base, input int pulse);
    int mn = (idx == SPECIAL) ? MIN_S : MIN_N;
    if (base[idx]) return mn;
    if (pulse >= 1 && pulse <= TIMEOUT) return (pulse > mn) ? pulse : mn;
    return TIMEOUT;
  endfunction

  function automatic bit slot_err(input int idx, input logic [NCH-1:0] base, input int pulse);
    return !(base[idx] || (pulse >= 1 && pulse <= TIMEOUT));
  endfunction

  // Waits (bounded) for a grant, drives acks through it and measures the slot.
  task automatic observe_slot(input logic [NCH-1:0] base, input int pulse, input int kill_at,
                              output int idx, output int len, output bit err,
                              output bit shape_ok, output int waited);
    idx = -1; len = 0; err = 1'b0; shape_ok = 1'b1; waited = 0;
    bus.ack = base;
    while (bus.grant == '0 && waited < 64) begin
      tick();
      waited++;
    end
    if (bus.grant == '0) return;
    idx = int'(bus.grant_idx);
    while (bus.grant != '0 && len < 64) begin
      len++;
      if (bus.grant !== (9'd1 << idx) || bus.special_active !== (idx == SPECIAL) ||
          bus.timeout_err !== 1'b0) shape_ok = 1'b0;
      bus.ack = base | ((len == pulse) ? (9'd1 << idx) : 9'd0);
      if (len == kill_at) begin
        bus.enable = 1'b0;
        bus.req    = '0;
      end
      tick();
    end
    bus.ack = base;
    err     = bus.timeout_err;
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.enable = 1'b1; bus.req = '1; bus.ack = '1;
    #3;
    total++; if (bus.grant !== '0) begin bad++; $display("FAIL reset_grant: got %h want 0", bus.grant); end
    total++; if (bus.grant_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d want 0", bus.grant_idx); end
    total++; if (bus.special_active !== 1'b0) begin bad++; $display("FAIL reset_special: got %b want 0", bus.special_active); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.timeout_err); end
    total++; if (bus.timeout_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.timeout_cnt); end
    tick();
    total++; if (bus.grant !== '0) begin bad++; $display("FAIL reset_hold: got %h want 0", bus.grant); end
  endtask

  task automatic test_single_ack();
    int idx, len, waited; bit err, ok, zeros;
    do_reset();
    bus.enable = 1'b1; bus.req = 9'h001;
    tick();
    total++; if (bus.grant !== '0) begin bad++; $display("FAIL single_early: got %h want 0", bus.grant); end
    tick();
    total++; if (bus.grant !== 9'h001) begin bad++; $display("FAIL single_latency: got %h want 001", bus.grant); end
    observe_slot(9'h000, 2, 0, idx, len, err, ok, waited);
    bus.req = '0;
    total++; if (idx !== 0) begin bad++; $display("FAIL single_idx: got %0d want 0", idx); end
    total++; if (len !== MIN_N) begin bad++; $display("FAIL single_len: got %0d want %0d", len, MIN_N); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_shape: got %b want 1", ok); end
    zeros = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.grant !== '0) zeros = 1'b0;
      tick();
    end
    total++; if (zeros !== 1'b1) begin bad++; $display("FAIL single_gap: got %b want 1", zeros); end
    total++; if (bus.timeout_cnt !== 8'd0) begin bad++; $display("FAIL single_cnt: got %0d want 0", bus.timeout_cnt); end
  endtask

  task automatic test_round_robin();
    int idx, len, waited, exp; bit err, ok;
    do_reset();
    bus.enable = 1'b1; bus.req = 9'h1FF;
    for (int s = 0; s < 10; s++) begin
      exp = rr_next(bus.req, model_last);
      observe_slot(9'h1FF, 0, 0, idx, len, err, ok, waited);
      total++; if (idx !== exp) begin bad++; $display("FAIL rr_idx[%0d]: got %0d want %0d", s, idx, exp); end
      total++; if (len !== slot_len(exp, 9'h1FF, 0)) begin bad++; $display("FAIL rr_len[%0d]: got %0d want %0d", s, len, slot_len(exp, 9'h1FF, 0)); end
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rr_shape[%0d]: got %b want 1", s, ok); end
      total++; if (waited !== 2) begin bad++; $display("FAIL rr_gap[%0d]: got %0d want 2", s, waited); end
      model_last = exp;
    end
  endtask

  task automatic test_timeout();
    int idx, len, waited; bit err, ok;
    do_reset();
    bus.enable = 1'b1; bus.req = 9'h004;
    observe_slot(9'h000, 0, 0, idx, len, err, ok, waited);
    total++; if (idx !== 2) begin bad++; $display("FAIL tmo_idx: got %0d want 2", idx); end
    total++; if (len !== TIMEOUT) begin bad++; $display("FAIL tmo_len: got %0d want %0d", len, TIMEOUT); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", err); end
    total++; if (bus.timeout_cnt !== 8'd1) begin bad++; $display("FAIL tmo_cnt1: got %0d want 1", bus.timeout_cnt); end
    tick();
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_pulse: got %b want 0", bus.timeout_err); end
    model_tmo = 1;
    observe_slot(9'h000, TIMEOUT, 0, idx, len, err, ok, waited);
    total++; if (len !== TIMEOUT) begin bad++; $display("FAIL ackwin_len: got %0d want %0d", len, TIMEOUT); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ackwin_err: got %b want 0", err); end
    total++; if (bus.timeout_cnt !== 8'(model_tmo)) begin bad++; $display("FAIL ackwin_cnt: got %0d want %0d", bus.timeout_cnt, model_tmo); end
    for (int i = 0; i < 299; i++) begin
      observe_slot(9'h000, 0, 0, idx, len, err, ok, waited);
      model_tmo = (model_tmo < ERR_MAX) ? model_tmo + 1 : ERR_MAX;
      total++; if (err !== 1'b1 || len !== TIMEOUT) begin bad++; $display("FAIL tmo_rep[%0d]: got err=%b len=%0d want err=1 len=%0d", i, err, len, TIMEOUT); end
    end
    total++; if (bus.timeout_cnt !== 8'(model_tmo)) begin bad++; $display("FAIL tmo_sat: got %0d want %0d", bus.timeout_cnt, model_tmo); end
  endtask

  task automatic test_foreign_ack();
    int idx, len, waited, exp; bit err, ok;
    do_reset();
    bus.enable = 1'b1; bus.req = 9'h104;
    for (int s = 0; s < 3; s++) begin
      exp = rr_next(bus.req, model_last);
      observe_slot(9'h008, 0, 0, idx, len, err, ok, waited);
      total++; if (idx !== exp) begin bad++; $display("FAIL foreign_idx[%0d]: got %0d want %0d", s, idx, exp); end
      total++; if (len !== TIMEOUT || err !== 1'b1) begin bad++; $display("FAIL foreign_tmo[%0d]: got len=%0d err=%b want len=%0d err=1", s, len, err, TIMEOUT); end
      model_last = exp;
    end
  endtask

  task automatic test_enable_drop();
    int idx, len, waited; bit err, ok, zeros;
    do_reset();
    bus.enable = 1'b1; bus.req = 9'h020;
    observe_slot(9'h000, 6, 3, idx, len, err, ok, waited);
    total++; if (idx !== 5) begin bad++; $display("FAIL drop_idx: got %0d want 5", idx); end
    total++; if (len !== 6) begin bad++; $display("FAIL drop_len: got %0d want 6", len); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL drop_err: got %b want 0", err); end
    bus.req = 9'h020;
    zeros = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.grant !== '0) zeros = 1'b0;
    end
    total++; if (zeros !== 1'b1) begin bad++; $display("FAIL drop_idle: got %b want 1", zeros); end
    bus.enable = 1'b1;
    tick();
    tick();
    total++; if (bus.grant !== 9'h020) begin bad++; $display("FAIL drop_resume: got %h want 020", bus.grant); end
    observe_slot(9'h000, 1, 0, idx, len, err, ok, waited);
    total++; if (len !== MIN_N) begin bad++; $display("FAIL drop_len2: got %0d want %0d", len, MIN_N); end
  endtask

  task automatic test_async_reset();
    int idx, len, waited, n, exp; bit err, ok;
    do_reset();
    bus.enable = 1'b1; bus.req = 9'h1FF;
    observe_slot(9'h000, 0, 0, idx, len, err, ok, waited);
    total++; if (bus.timeout_cnt !== 8'd1) begin bad++; $display("FAIL areset_pre_cnt: got %0d want 1", bus.timeout_cnt); end
    model_last = idx;
    n = 0;
    while (bus.grant == '0 && n < 8) begin
      tick();
      n++;
    end
    exp = rr_next(bus.req, model_last);
    total++; if (int'(bus.grant_idx) !== exp || bus.grant == '0) begin bad++; $display("FAIL areset_pre_idx: got %0d want %0d", bus.grant_idx, exp); end
    tick();
    #2;
    rstn = 1'b0;
    #1;
    total++; if (bus.grant !== '0) begin bad++; $display("FAIL areset_grant: got %h want 0", bus.grant); end
    total++; if (bus.timeout_cnt !== 8'd0) begin bad++; $display("FAIL areset_cnt: got %0d want 0", bus.timeout_cnt); end
    @(negedge clk40);
    rstn = 1'b1;
    model_last = NCH - 1;
    model_tmo  = 0;
    exp = rr_next(bus.req, model_last);
    observe_slot(9'h000, 1, 0, idx, len, err, ok, waited);
    total++; if (idx !== exp) begin bad++; $display("FAIL areset_restart: got %0d want %0d", idx, exp); end
  endtask

  task automatic test_random();
    int idx, len, waited, exp, pulse; bit err, ok;
    logic [NCH-1:0] r, base;
    do_reset();
    bus.enable = 1'b1;
    for (int s = 0; s < 40; s++) begin
      r     = 9'($urandom_range(1, 511));
      base  = 9'($urandom);
      pulse = int'($urandom_range(0, 18));
      bus.req = r;
      exp   = rr_next(r, model_last);
      base  = base & ~(9'd1 << exp);
      observe_slot(base, pulse, 0, idx, len, err, ok, waited);
      total++; if (idx !== exp) begin bad++; $display("FAIL rand_idx[%0d]: got %0d want %0d", s, idx, exp); end
      total++; if (len !== slot_len(exp, base, pulse)) begin bad++; $display("FAIL rand_len[%0d]: got %0d want %0d", s, len, slot_len(exp, base, pulse)); end
      total++; if (err !== slot_err(exp, base, pulse)) begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", s, err, slot_err(exp, base, pulse)); end
      total++; if (ok !== 1'b1 || waited !== 2) begin bad++; $display("FAIL rand_shape[%0d]: got ok=%b wait=%0d want ok=1 wait=2", s, ok, waited); end
      if (slot_err(exp, base, pulse)) model_tmo++;
      model_last = exp;
    end
    total++; if (bus.timeout_cnt !== 8'(model_tmo)) begin bad++; $display("FAIL rand_cnt: got %0d want %0d", bus.timeout_cnt, model_tmo); end
  endtask

  initial begin
    rstn       = 1'b0;
    bus.enable = 1'b0;
    bus.req    = '0;
    bus.ack    = '0;
    test_reset();
    test_single_ack();
    test_round_robin();
    test_timeout();
    test_foreign_ack();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
